calc_entry_ctrl: RTL
====================

Name: calc_entry_ctrl

Overview:
Sequencer between the keypad scanner and the calculator arithmetic unit. It debounces the scanner's key-valid strobe and 4-bit key code, then builds BCD operands A and B digit by digit. It captures the operator, issues one req/ack compute transaction to the ALU, and holds the value to show on the display. All calculator entry behaviour is decided here, not in the scanner or the ALU.

Parameters:
NDIGITS, 4, BCD digits per operand; operand width is 4*NDIGITS bits.
DEB_CYCLES, 16, consecutive stable cycles needed to accept a press, and again to accept a release.

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
key_valid  in  1  scanner key-pressed strobe (level)
key_code  in  4  scanner key code; 0-9 digit, 10 ADD, 11 SUB, 12 MUL, 13 DIV, 14 EQUALS, 15 CLEAR
alu_req  out  1  compute request, level, held until ack
alu_op  out  2  0 ADD, 1 SUB, 2 MUL, 3 DIV; stable while alu_req=1
op_a  out  4*NDIGITS  operand A (BCD, most significant digit first)
op_b  out  4*NDIGITS  operand B (BCD)
alu_ack  in  1  one-cycle completion pulse
alu_result  in  4*NDIGITS  BCD result; valid when alu_ack=1
alu_err  in  1  error flag (e.g. divide by zero, overflow); valid when alu_ack=1
disp_bcd  out  4*NDIGITS  value to display
err_flag  out  1  high while in S_ERR
busy  out  1  high while in S_REQ

Behaviour:
- Reset (asynchronous): state S_A; op_a, op_b, alu_op, digit counters all 0; alu_req=0; err_flag=0; busy=0; debouncer in released-idle.
- Debounce, press:
  - key_valid must be high for DEB_CYCLES consecutive cycles.
  - Then key_event pulses for exactly 1 cycle, carrying key_code sampled in that last cycle.
- Debounce, release:
  - After a press the debouncer is locked.
  - key_valid must be low for DEB_CYCLES consecutive cycles before the next press can be accepted.
  - A glitch resets the run counter.
- Event latency: each key is acted on in the cycle after key_event; results appear on registered outputs 1 cycle later.
- Digit entry (S_A into A, S_B into B):
  - If the operand's count < NDIGITS: operand <= {operand[4*NDIGITS-5:0], digit}; count+1.
  - If count = NDIGITS: the digit is ignored, the operand is unchanged, there is no wrap.
- S_A:
  - digit: append to A.
  - operator: alu_op <= op; clear B and its count; go to S_B. An operator with A count 0 uses A=0.
  - EQUALS: ignored.
  - CLEAR: reset A.
- S_B:
  - digit: append to B.
  - operator with B count 0: replaces alu_op.
  - operator with B count > 0: ignored.
  - EQUALS with B count > 0: go to S_REQ, assert alu_req next cycle.
  - EQUALS with B count 0: ignored.
- S_REQ:
  - alu_req=1; op_a, op_b and alu_op are frozen.
  - Keys other than CLEAR are dropped, not queued.
  - On alu_ack with alu_err=0: op_a <= alu_result; A count <= NDIGITS; alu_req <= 0; go to S_RES.
  - On alu_ack with alu_err=1: alu_req <= 0; go to S_ERR.
- S_RES:
  - digit: clear A, load the digit (count 1), go to S_A.
  - operator: keep the result as A (chaining), set alu_op, clear B, go to S_B.
  - EQUALS: ignored.
- S_ERR: err_flag=1; all keys except CLEAR ignored.
- CLEAR, any state:
  - Next state S_A; A, B and both counts cleared; alu_op=0; alu_req dropped the next cycle.
  - CLEAR in the same cycle as alu_ack: CLEAR wins and the result is discarded.
  - An alu_ack arriving outside S_REQ is ignored.
- disp_bcd: op_b when state is S_B and B count > 0; otherwise op_a. In S_ERR, disp_bcd=0.
- Reset mid-transaction: alu_req drops asynchronously; any later ack is ignored.

Decomposition:
- Shared package calc_pkg:
  - key-code constants (KEY_ADD=10 .. KEY_CLR=15);
  - ALU op encoding (2 bits);
  - state enum S_A, S_B, S_REQ, S_RES, S_ERR;
  - NDIGITS default.
- One natural sub-module: key_debounce.
  - Inputs: CLK, RESET, key_valid, key_code.
  - Outputs: key_event, key_code_q.
  - Parameter: DEB_CYCLES.
- The FSM and operand registers remain in calc_entry_ctrl.

Test Plan:
(All with DEB_CYCLES=2, NDIGITS=4.)
1. Key 1, 2 pressed and released cleanly -> exactly two key_event pulses; op_a=0x0012; disp_bcd=0x0012. A 1-cycle bounce on key_valid produces no event.
2. Sequence 5, ADD, 3, EQUALS -> alu_req rises with op_a=0x0005, op_b=0x0003, alu_op=0; busy=1. ALU acks after 7 cycles with result 0x0008 -> alu_req falls the next cycle; op_a=0x0008; disp_bcd=0x0008; state S_RES.
3. Enter 1,2,3,4,5 -> op_a=0x1234, fifth digit ignored. Then SUB, MUL -> alu_op=2, state S_B.
4. 9, DIV, 0, EQUALS; ack with alu_err=1 -> err_flag=1, disp_bcd=0. Digit 7 is ignored. CLEAR -> err_flag=0, op_a=0, state S_A.
5. In S_RES after result 0x0008, press MUL, 2, EQUALS -> op_a=0x0008, op_b=0x0002, alu_op=2, alu_req=1 (chaining).
6. CLEAR during S_REQ, with alu_ack pulsed in the same cycle -> alu_req=0 the next cycle; op_a=0, not the result. Separately, RESET asserted mid-S_REQ -> all outputs 0 immediately.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, ALU op encoding, entry FSM states.
// Pure declarations; no timing or flow-control behaviour.
package calc_pkg;

  localparam int CALC_NDIGITS = 4;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    S_A   = 3'd0,
    S_B   = 3'd1,
    S_REQ = 3'd2,
    S_RES = 3'd3,
    S_ERR = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    K_DIGIT = 2'd0,
    K_OP    = 2'd1,
    K_EQ    = 2'd2,
    K_CLR   = 2'd3
  } key_class_e;

  function automatic key_class_e classify_key(input logic [3:0] code);
    if (code <= 4'd9)         return K_DIGIT;
    else if (code == KEY_EQ)  return K_EQ;
    else if (code == KEY_CLR) return K_CLR;
    else                      return K_OP;
  endfunction

  // Operator keys 10..13 map onto ops 0..3; low two bits minus 2 does the offset.
  function automatic alu_op_e key_to_op(input logic [3:0] code);
    return alu_op_e'(code[1:0] - 2'd2);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces key_valid: DEB_CYCLES stable-high cycles emit a 1-cycle key_event, then DEB_CYCLES
// stable-low cycles re-arm. Registered outputs; no backpressure, events are never held.
module key_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_event,
  output logic [3:0] key_code_q
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          locked_q, locked_d;
  logic [CW-1:0] run_q, run_d;
  logic          event_q, event_d;
  logic [3:0]    code_q, code_d;

  always_comb begin
    locked_d = locked_q;
    run_d    = run_q;
    event_d  = 1'b0;
    code_d   = code_q;
    // Unlocked: count high cycles to accept a press. Locked: count low cycles to accept release.
    if (!locked_q) begin
      if (key_valid) begin
        if (run_q == CW'(DEB_CYCLES - 1)) begin
          event_d  = 1'b1;
          code_d   = key_code;
          locked_d = 1'b1;
          run_d    = '0;
        end else begin
          run_d = run_q + 1'b1;
        end
      end else begin
        run_d = '0;
      end
    end else begin
      if (!key_valid) begin
        if (run_q == CW'(DEB_CYCLES - 1)) begin
          locked_d = 1'b0;
          run_d    = '0;
        end else begin
          run_d = run_q + 1'b1;
        end
      end else begin
        run_d = '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      locked_q <= 1'b0;
      run_q    <= '0;
      event_q  <= 1'b0;
      code_q   <= '0;
    end else begin
      locked_q <= locked_d;
      run_q    <= run_d;
      event_q  <= event_d;
      code_q   <= code_d;
    end
  end

  assign key_event  = event_q;
  assign key_code_q = code_q;

endmodule

// File: rtl/calc_entry_ctrl.sv
// Calculator entry sequencer: debounced keys build BCD operands, one req/ack ALU transaction per EQUALS.
// Keys act one cycle after key_event; keys arriving while alu_req is held (except CLEAR) are dropped.
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int NDIGITS    = CALC_NDIGITS,
  parameter int DEB_CYCLES = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 key_valid,
  input  logic [3:0]           key_code,
  output logic                 alu_req,
  output logic [1:0]           alu_op,
  output logic [4*NDIGITS-1:0] op_a,
  output logic [4*NDIGITS-1:0] op_b,
  input  logic                 alu_ack,
  input  logic [4*NDIGITS-1:0] alu_result,
  input  logic                 alu_err,
  output logic [4*NDIGITS-1:0] disp_bcd,
  output logic                 err_flag,
  output logic                 busy
);

  localparam int W    = 4 * NDIGITS;
  localparam int CNTW = $clog2(NDIGITS + 1);

  logic       key_event;
  logic [3:0] key_code_ev;

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .CLK        (CLK),
    .RESET      (RESET),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_event  (key_event),
    .key_code_q (key_code_ev)
  );

  state_e          state_q, state_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  logic [CNTW-1:0] cnt_a_q, cnt_a_d;
  logic [CNTW-1:0] cnt_b_q, cnt_b_d;
  alu_op_e         alu_op_q, alu_op_d;
  logic            alu_req_q;
  key_class_e      kcls;
  alu_op_e         kop;

  assign kcls = classify_key(key_code_ev);
  assign kop  = key_to_op(key_code_ev);

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    alu_op_d = alu_op_q;
    // CLEAR outranks everything, including an ack landing in the same cycle.
    if (key_event && kcls == K_CLR) begin
      state_d  = S_A;
      op_a_d   = '0;
      op_b_d   = '0;
      cnt_a_d  = '0;
      cnt_b_d  = '0;
      alu_op_d = OP_ADD;
    end else begin
      case (state_q)
        S_A: begin
          if (key_event) begin
            case (kcls)
              K_DIGIT: begin
                if (cnt_a_q < CNTW'(NDIGITS)) begin
                  op_a_d  = {op_a_q[W-5:0], key_code_ev};
                  cnt_a_d = cnt_a_q + 1'b1;
                end
              end
              K_OP: begin
                alu_op_d = kop;
                op_b_d   = '0;
                cnt_b_d  = '0;
                state_d  = S_B;
              end
              default: ;
            endcase
          end
        end
        S_B: begin
          if (key_event) begin
            case (kcls)
              K_DIGIT: begin
                if (cnt_b_q < CNTW'(NDIGITS)) begin
                  op_b_d  = {op_b_q[W-5:0], key_code_ev};
                  cnt_b_d = cnt_b_q + 1'b1;
                end
              end
              K_OP: begin
                if (cnt_b_q == '0) alu_op_d = kop;
              end
              K_EQ: begin
                if (cnt_b_q != '0) state_d = S_REQ;
              end
              default: ;
            endcase
          end
        end
        S_REQ: begin
          if (alu_ack) begin
            if (alu_err) begin
              state_d = S_ERR;
            end else begin
              op_a_d  = alu_result;
              cnt_a_d = CNTW'(NDIGITS);
              state_d = S_RES;
            end
          end
        end
        S_RES: begin
          if (key_event) begin
            case (kcls)
              K_DIGIT: begin
                op_a_d  = {{(W-4){1'b0}}, key_code_ev};
                cnt_a_d = CNTW'(1);
                state_d = S_A;
              end
              K_OP: begin
                alu_op_d = kop;
                op_b_d   = '0;
                cnt_b_d  = '0;
                state_d  = S_B;
              end
              default: ;
            endcase
          end
        end
        S_ERR: ;
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_A;
      op_a_q    <= '0;
      op_b_q    <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      alu_op_q  <= OP_ADD;
      alu_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      alu_op_q  <= alu_op_d;
      alu_req_q <= (state_d == S_REQ);
    end
  end

  assign alu_req  = alu_req_q;
  assign alu_op   = alu_op_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign err_flag = (state_q == S_ERR);
  assign busy     = (state_q == S_REQ);

  always_comb begin
    if (state_q == S_ERR)                      disp_bcd = '0;
    else if (state_q == S_B && cnt_b_q != '0)  disp_bcd = op_b_q;
    else                                       disp_bcd = op_a_q;
  end

endmodule
